// File: rtl/fmap_stream_reader.sv
// rtl/fmap_stream_reader.sv - raster reader for one WIDTH x WIDTH plane from a sync-read buffer
// Issues one read per cycle with optional inter-row gaps; coordinates ride a RD_LAT-deep delay line.
module fmap_stream_reader #(
  parameter int WIDTH   = 5,
  parameter int ADDR_W  = 16,
  parameter int RD_LAT  = 1,
  parameter int ROW_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              valid_out,
  output logic [31:0]       counter_col,
  output logic [31:0]       counter_row,
  output logic              frame_last,
  output logic              done
);

  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [31:0]      EDGE     = 32'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, READ, GAP, DRAIN, DONE} state_t;

  state_t           state;
  logic [31:0]      icol;
  logic [31:0]      irow;
  logic [GAP_W-1:0] gap_cnt;
  logic [LAT_W-1:0] drain_cnt;
  logic             ilast;

  // icol/irow always describe the read presented on rd_en this cycle.
  assign ilast = rd_en && (icol == EDGE) && (irow == EDGE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      done      <= 1'b0;
      icol      <= '0;
      irow      <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= base_addr;
            icol    <= '0;
            irow    <= '0;
          end
        end
        READ: begin
          if (icol == EDGE) begin
            if (irow == EDGE) begin
              state     <= DRAIN;
              rd_en     <= 1'b0;
              drain_cnt <= '0;
            end else begin
              irow    <= irow + 32'd1;
              icol    <= '0;
              rd_addr <= rd_addr + ADDR_W'(1);
              if (ROW_GAP > 0) begin
                state   <= GAP;
                rd_en   <= 1'b0;
                gap_cnt <= '0;
              end
            end
          end else begin
            icol    <= icol + 32'd1;
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= READ;
            rd_en <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Coordinates only advance with a valid entry, so the last stage holds between pixels.
  logic        pv [RD_LAT];
  logic        pl [RD_LAT];
  logic [31:0] pc [RD_LAT];
  logic [31:0] pr [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pl[i] <= 1'b0;
        pc[i] <= '0;
        pr[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en;
      pl[0] <= ilast;
      if (rd_en) begin
        pc[0] <= icol;
        pr[0] <= irow;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        if (pv[i-1]) begin
          pc[i] <= pc[i-1];
          pr[i] <= pr[i-1];
        end
      end
    end
  end

  assign valid_out   = pv[RD_LAT-1];
  assign frame_last  = pl[RD_LAT-1];
  assign counter_col = pc[RD_LAT-1];
  assign counter_row = pr[RD_LAT-1];

endmodule

// File: tb/tb_fmap_stream_reader.sv
// tb/tb_fmap_stream_reader.sv - scoreboard bench for fmap_stream_reader
// Three instances cover the default geometry, a deep/gapless pipeline and address wrap.
module tb_fmap_stream_reader;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    int   col;
    int   row;
    logic last;
    int   cyc;
  } px_t;

  int w_of   [3] = '{5, 5, 2};
  int lat_of [3] = '{1, 3, 1};
  int gap_of [3] = '{2, 0, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start_v = '0;
  logic [15:0] base_v [3] = '{16'h0, 16'h0, 16'h0};
  logic [2:0]  busy_v, rd_en_v, valid_v, last_v, done_v;
  logic [15:0] addr_v [3];
  logic [31:0] col_v [3];
  logic [31:0] row_v [3];

  rd_t rd_q [3][$];
  px_t px_q [3][$];
  int  done_q [3][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmap_stream_reader #(.WIDTH(5), .ADDR_W(16), .RD_LAT(1), .ROW_GAP(2)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_v[0]), .busy(busy_v[0]),
    .rd_en(rd_en_v[0]), .rd_addr(addr_v[0]), .valid_out(valid_v[0]), .counter_col(col_v[0]),
    .counter_row(row_v[0]), .frame_last(last_v[0]), .done(done_v[0]));

  fmap_stream_reader #(.WIDTH(5), .ADDR_W(16), .RD_LAT(3), .ROW_GAP(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_v[1]), .busy(busy_v[1]),
    .rd_en(rd_en_v[1]), .rd_addr(addr_v[1]), .valid_out(valid_v[1]), .counter_col(col_v[1]),
    .counter_row(row_v[1]), .frame_last(last_v[1]), .done(done_v[1]));

  fmap_stream_reader #(.WIDTH(2), .ADDR_W(16), .RD_LAT(1), .ROW_GAP(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .base_addr(base_v[2]), .busy(busy_v[2]),
    .rd_en(rd_en_v[2]), .rd_addr(addr_v[2]), .valid_out(valid_v[2]), .counter_col(col_v[2]),
    .counter_row(row_v[2]), .frame_last(last_v[2]), .done(done_v[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input int i, input logic [15:0] base);
    int n, w, g, l, rc;
    rd_t r;
    px_t p;
    n = cyc;
    w = w_of[i];
    g = gap_of[i];
    l = lat_of[i];
    base_v[i]  = base;
    start_v[i] = 1'b1;
    for (int row = 0; row < w; row++) begin
      for (int col = 0; col < w; col++) begin
        rc     = n + 1 + row * (w + g) + col;
        r.addr = base + 16'(row * w + col);
        r.cyc  = rc;
        rd_q[i].push_back(r);
        p.col  = col;
        p.row  = row;
        p.last = (row == w - 1) && (col == w - 1);
        p.cyc  = rc + l;
        px_q[i].push_back(p);
      end
    end
    done_q[i].push_back(n + 1 + w * w + (w - 1) * g + l);
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    chk($sformatf("u%0d busy_after_start", i), busy_v[i], 1);
  endtask

  task automatic chk_quiet(input int i, input string tag);
    chk($sformatf("u%0d %s busy", i, tag), busy_v[i], 0);
    chk($sformatf("u%0d %s rd_en", i, tag), rd_en_v[i], 0);
    chk($sformatf("u%0d %s rd_addr", i, tag), addr_v[i], 0);
    chk($sformatf("u%0d %s valid", i, tag), valid_v[i], 0);
    chk($sformatf("u%0d %s col", i, tag), col_v[i], 0);
    chk($sformatf("u%0d %s row", i, tag), row_v[i], 0);
    chk($sformatf("u%0d %s last", i, tag), last_v[i], 0);
    chk($sformatf("u%0d %s done", i, tag), done_v[i], 0);
  endtask

  always @(negedge clk) begin
    rd_t r;
    px_t p;
    int  d;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (rd_en_v[i]) begin
          if (rd_q[i].size() == 0) chk($sformatf("u%0d unexpected_rd_en", i), 1, 0);
          else begin
            r = rd_q[i].pop_front();
            chk($sformatf("u%0d rd_addr", i), addr_v[i], r.addr);
            chk($sformatf("u%0d rd_cycle", i), cyc, r.cyc);
          end
        end
        if (valid_v[i]) begin
          if (px_q[i].size() == 0) chk($sformatf("u%0d unexpected_valid", i), 1, 0);
          else begin
            p = px_q[i].pop_front();
            chk($sformatf("u%0d col", i), col_v[i], p.col);
            chk($sformatf("u%0d row", i), row_v[i], p.row);
            chk($sformatf("u%0d frame_last", i), last_v[i], p.last);
            chk($sformatf("u%0d valid_cycle", i), cyc, p.cyc);
          end
        end else if (last_v[i]) begin
          chk($sformatf("u%0d last_without_valid", i), 1, 0);
        end
        if (done_v[i]) begin
          if (done_q[i].size() == 0) chk($sformatf("u%0d unexpected_done", i), 1, 0);
          else begin
            d = done_q[i].pop_front();
            chk($sformatf("u%0d done_cycle", i), cyc, d);
            chk($sformatf("u%0d busy_at_done", i), busy_v[i], 0);
            chk($sformatf("u%0d held_col", i), col_v[i], w_of[i] - 1);
            chk($sformatf("u%0d held_row", i), row_v[i], w_of[i] - 1);
          end
        end
      end
    end
  end

  initial begin
    int n0, n;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    start_frame(1, 16'h0200);
    start_frame(2, 16'hFFFE);
    n0 = cyc;
    start_frame(0, 16'h0100);

    // mid-frame start must be ignored
    wait_cyc(n0 + 10);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;

    // start held through the DONE cycle: ignored there, accepted the cycle after
    wait_cyc(n0 + 35);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_frame(0, 16'h0300);

    wait_cyc(n0 + 80);
    n = cyc;
    start_frame(0, 16'h0400);
    wait_cyc(n + 19);
    #2;
    rst = 1'b0;
    #1;
    chk_quiet(0, "async_reset");
    rd_q[0].delete();
    px_q[0].delete();
    done_q[0].delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    start_frame(0, 16'h0500);

    for (int k = 0; k < 200; k++) begin
      if (rd_q[0].size() + px_q[0].size() + done_q[0].size() +
          rd_q[1].size() + px_q[1].size() + done_q[1].size() +
          rd_q[2].size() + px_q[2].size() + done_q[2].size() == 0) break;
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d pending_reads", i), rd_q[i].size(), 0);
      chk($sformatf("u%0d pending_pixels", i), px_q[i].size(), 0);
      chk($sformatf("u%0d pending_done", i), done_q[i].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
